ecc_memory_scrubber: RTL and testbench
======================================

ECC_MEMORY_SCRUBBER -- requirements
Module: ecc_memory_scrubber

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data bits per word; CODE_WIDTH, default 12, Hamming codeword bits; ADDR_WIDTH, default 5, word address bits; READ_LATENCY, default 5, memory read latency in clocks; DEPTH, default 2**ADDR_WIDTH, words scrubbed per pass.
REQ-002 Ports SHALL be (clock and reset first):
- i_clk  in  1  single clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  begin a pass.
- i_abort  in  1  terminate the pass.
- o_mem_en  out  1  memory port enable.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_din  out  CODE_WIDTH  write-back codeword.
- i_mem_dout  in  CODE_WIDTH  read codeword.
- o_busy  out  1  pass in progress.
- o_done  out  1  one-cycle end-of-pass pulse.
- o_corr_count  out  ADDR_WIDTH+1  corrected words.
- o_uncorr_count  out  ADDR_WIDTH+1  uncorrectable words.
- o_last_err_addr  out  ADDR_WIDTH  address of most recent error.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 Codeword position p (1..12) SHALL occupy bit p-1; parity SHALL sit at positions 1, 2, 4, 8; data LSB-first SHALL sit at 3, 5, 6, 7, 9, 10, 11, 12.
REQ-005 Syndrome bit k SHALL be the XOR of all codeword bits whose position has bit k set.
- Syndrome 0: clean.
- Syndrome 1..12: correctable; flip that position.
- Syndrome 13..15: uncorrectable.
REQ-006 FSM states SHALL be IDLE, READ, WAIT, CHECK, WRITE, NEXT and DONE.
REQ-007 IDLE->READ SHALL occur on i_start; on acceptance, address and both counters SHALL clear to 0.
REQ-008 READ SHALL last one cycle with o_mem_en=1, o_mem_we=0 and o_mem_addr=current address.
REQ-009 WAIT SHALL last exactly READ_LATENCY cycles; CHECK SHALL sample i_mem_dout in its single cycle.
REQ-010 From CHECK:
- Correctable: increment o_corr_count, update o_last_err_addr, go to WRITE.
- Uncorrectable: increment o_uncorr_count, update o_last_err_addr, go to NEXT with no write.
- Clean: go to NEXT.
REQ-011 WRITE SHALL last one cycle with o_mem_en=1, o_mem_we=1, same address and o_mem_din=corrected codeword.
REQ-012 NEXT SHALL go to DONE if address==DEPTH-1, otherwise increment the address and go to READ.
REQ-013 DONE SHALL assert o_done for exactly one cycle, then go to IDLE.
REQ-014 o_busy SHALL be 1 in every state except IDLE.
REQ-015 o_mem_en and o_mem_we SHALL be 0 outside READ and WRITE.
REQ-016 Per-word cycles SHALL be READ_LATENCY+3 for clean or uncorrectable words and READ_LATENCY+4 for corrected words.
REQ-017 i_start SHALL be ignored while o_busy=1.
REQ-018 i_abort in READ, WAIT, CHECK or NEXT SHALL go to IDLE with no o_done and no counter update for the current word.
REQ-019 i_abort in WRITE SHALL let the write complete, then go to IDLE.
REQ-020 Simultaneous i_start and i_abort in IDLE SHALL be treated as abort, so the state stays IDLE.
REQ-021 Counters SHALL saturate at all-ones; counters and o_last_err_addr SHALL hold their values after DONE or abort until the next accepted start.

Reset
REQ-022 i_rst SHALL force IDLE and clear all outputs, the address and the wait counter to 0 at the next edge, including mid-pass and mid-WRITE; an interrupted write is not guaranteed.

Configuration
REQ-023 With SCRUB_WRITEBACK_EN defined, REQ-011 behaviour SHALL apply.
REQ-024 Without SCRUB_WRITEBACK_EN, the block SHALL be report-only:
- WRITE is unreachable and CHECK goes to NEXT.
- o_mem_we and o_mem_din are constant 0.
- Counting is unchanged.

Structure
REQ-025 A shared package SHALL hold the state enum, the parity-position constants and a syndrome-to-status enum (CLEAN/CORR/UNCORR).
REQ-026 One combinational sub-module, ecc_scrub_decoder, SHALL take a codeword and produce the syndrome, status and corrected codeword; the FSM, counters and latency timer SHALL stay in ecc_memory_scrubber.

Verification
REQ-027 The bench SHALL cover these scenarios (defaults, WRITEBACK_EN defined, behavioural memory with latency 5):
- Clean pass: all 32 words hold the encoding of 0x00..0x1F; start -> 32 reads, 0 writes, o_done 256 cycles after start acceptance, both counts 0.
- Single error: addr 3 holds the encoding of 0xA5 with position 6 flipped -> one write at addr 3 of the exact 0xA5 codeword, o_corr_count=1, o_last_err_addr=3, o_done after 257 cycles.
- Uncorrectable: addr 7 has positions 5 and 8 flipped (syndrome 13) -> no write, o_uncorr_count=1, o_last_err_addr=7.
- Abort: i_abort pulsed during the WAIT of addr 10 -> IDLE next cycle, no o_done, o_busy=0; a later start rescans from addr 0 with counts cleared.
- Reset mid-WRITE: i_rst during the write of addr 3 -> all outputs 0 next cycle; start during busy ignored; start+abort in IDLE stays IDLE.
- Report-only build (macro undefined): the single-error scenario -> o_mem_we never 1, o_corr_count=1.

Source files
------------

// File: rtl/ecc_memory_scrubber_pkg.sv
// ---------------------------------------------------------------------------
// ecc_memory_scrubber_pkg
// Shared definitions for the ECC memory scrubber:
//   - FSM state encoding (IDLE, READ, WAIT, CHECK, WRITE, NEXT, DONE)
//   - Hamming(12,8) parity-position and syndrome masks
//   - decoder status enum (CLEAN / CORR / UNCORR)
//   - helper functions: syndrome, status classification, data extraction
// Codeword position p (1..12) lives in bit p-1; parity at positions 1,2,4,8.
// ---------------------------------------------------------------------------
package ecc_memory_scrubber_pkg;

   localparam int unsigned ECC_DATA_W = 8;
   localparam int unsigned ECC_CODE_W = 12;
   localparam int unsigned ECC_SYN_W  = 4;

   // FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_READ  = 3'd1;
   localparam state_t S_WAIT  = 3'd2;
   localparam state_t S_CHECK = 3'd3;
   localparam state_t S_WRITE = 3'd4;
   localparam state_t S_NEXT  = 3'd5;
   localparam state_t S_DONE  = 3'd6;

   // Bits holding parity (positions 1, 2, 4, 8 -> bits 0, 1, 3, 7)
   localparam logic [11:0] PARITY_POS_MASK = 12'h08B;

   // Syndrome bit k covers every position whose index has bit k set
   localparam logic [11:0] SYN_MASK_0 = 12'h555;  // positions 1,3,5,7,9,11
   localparam logic [11:0] SYN_MASK_1 = 12'h666;  // positions 2,3,6,7,10,11
   localparam logic [11:0] SYN_MASK_2 = 12'h878;  // positions 4,5,6,7,12
   localparam logic [11:0] SYN_MASK_3 = 12'hF80;  // positions 8..12

   typedef enum logic [1:0] {
      ECC_CLEAN  = 2'd0,
      ECC_CORR   = 2'd1,
      ECC_UNCORR = 2'd2
   } ecc_status_e;

   function automatic logic [3:0] ecc_syndrome(input logic [11:0] code);
      return {^(code & SYN_MASK_3), ^(code & SYN_MASK_2),
              ^(code & SYN_MASK_1), ^(code & SYN_MASK_0)};
   endfunction

   // Syndromes beyond the last codeword position cannot name a bit to flip
   function automatic ecc_status_e ecc_classify(input logic [3:0] syn);
      ecc_status_e st;
      if (syn == 4'd0) begin
         st = ECC_CLEAN;
      end else if (syn <= 4'd12) begin
         st = ECC_CORR;
      end else begin
         st = ECC_UNCORR;
      end
      return st;
   endfunction

   // Gather data bits LSB-first from the non-parity positions
   function automatic logic [7:0] ecc_extract_data(input logic [11:0] code);
      logic [7:0] d;
      int unsigned j;
      d = 8'h00;
      j = 0;
      for (int b = 0; b < 12; b++) begin
         if (!PARITY_POS_MASK[b]) begin
            d[j[2:0]] = code[b];
            j = j + 1;
         end else begin
            j = j;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/ecc_scrub_decoder.sv
// ---------------------------------------------------------------------------
// ecc_scrub_decoder
// Purely combinational Hamming(12,8) single-error-correcting decoder.
// Ports:
//   i_code      in  CODE_WIDTH  codeword read from memory
//   o_syndrome  out 4           raw syndrome (0 = clean)
//   o_status    out 2           CLEAN / CORR / UNCORR
//   o_corrected out CODE_WIDTH  codeword with the indicated bit flipped
//   o_data      out WIDTH       data bits of the corrected codeword
// ---------------------------------------------------------------------------
module ecc_scrub_decoder
   import ecc_memory_scrubber_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned CODE_WIDTH = 12
) (
   input  logic [CODE_WIDTH-1:0] i_code,
   output logic [3:0]            o_syndrome,
   output ecc_status_e           o_status,
   output logic [CODE_WIDTH-1:0] o_corrected,
   output logic [WIDTH-1:0]      o_data
);

   localparam logic [CODE_WIDTH-1:0] ONE = {{(CODE_WIDTH-1){1'b0}}, 1'b1};

   // Syndrome, classification and single-bit correction
   always_comb begin
      o_syndrome = ecc_syndrome(i_code);
      o_status   = ecc_classify(o_syndrome);
      if (o_status == ECC_CORR) begin
         // syndrome value is the 1-based position of the faulty bit
         o_corrected = i_code ^ (ONE << (o_syndrome - 4'd1));
      end else begin
         o_corrected = i_code;
      end
      o_data = ecc_extract_data(o_corrected);
   end

endmodule

// File: rtl/ecc_memory_scrubber.sv
// ---------------------------------------------------------------------------
// ecc_memory_scrubber
// Walks every word of an ECC-protected memory, checks its Hamming(12,8)
// codeword, counts corrected / uncorrectable words and (optionally) writes
// the corrected codeword back.
// Build option: SCRUB_WRITEBACK_EN -- when defined, correctable words are
// written back; when undefined the block is report-only (o_mem_we and
// o_mem_din tied to 0, counting unchanged).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_abort    begin / terminate a pass
//   o_mem_en, o_mem_we  memory enable / write enable
//   o_mem_addr          memory address
//   o_mem_din           write-back codeword
//   i_mem_dout          read codeword (valid READ_LATENCY clocks after READ)
//   o_busy, o_done      pass in progress / one-cycle end-of-pass pulse
//   o_corr_count        corrected words (saturating)
//   o_uncorr_count      uncorrectable words (saturating)
//   o_last_err_addr     address of most recent error
// All outputs are registered.
// ---------------------------------------------------------------------------
module ecc_memory_scrubber
   import ecc_memory_scrubber_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CODE_WIDTH   = 12,
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned READ_LATENCY = 5,
   parameter int unsigned DEPTH        = 2**ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_abort,
   output logic                  o_mem_en,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [CODE_WIDTH-1:0] o_mem_din,
   input  logic [CODE_WIDTH-1:0] i_mem_dout,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [ADDR_WIDTH:0]   o_corr_count,
   output logic [ADDR_WIDTH:0]   o_uncorr_count,
   output logic [ADDR_WIDTH-1:0] o_last_err_addr
);

   // The decoder implements the fixed Hamming(12,8) layout only
   if ((WIDTH != ECC_DATA_W) || (CODE_WIDTH != ECC_CODE_W)) begin : g_cfg_err
      $error("ecc_memory_scrubber supports only WIDTH=8, CODE_WIDTH=12");
   end

   localparam int unsigned WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   CNT_MAX   = {(ADDR_WIDTH+1){1'b1}};

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WAIT_W-1:0]     r_wait;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_mem_en;
   logic [ADDR_WIDTH:0]   r_corr;
   logic [ADDR_WIDTH:0]   r_uncorr;
   logic [ADDR_WIDTH-1:0] r_last_err;

   logic [3:0]            w_syndrome;
   ecc_status_e           w_status;
   logic [CODE_WIDTH-1:0] w_corrected;
   logic [WIDTH-1:0]      w_data;
   logic                  w_unused_ok;

   ecc_scrub_decoder #(
      .WIDTH      (WIDTH),
      .CODE_WIDTH (CODE_WIDTH)
   ) u_decoder (
      .i_code      (i_mem_dout),
      .o_syndrome  (w_syndrome),
      .o_status    (w_status),
      .o_corrected (w_corrected),
      .o_data      (w_data)
   );

   // Next-state logic; abort wins everywhere except WRITE and DONE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               w_state_nxt = S_READ;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_READ: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else if (r_wait == WAIT_LAST) begin
               w_state_nxt = S_CHECK;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_CHECK: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
`ifdef SCRUB_WRITEBACK_EN
            end else if (w_status == ECC_CORR) begin
               w_state_nxt = S_WRITE;
`endif
            end else begin
               w_state_nxt = S_NEXT;
            end
         end
         S_WRITE: begin
            // the write itself is this cycle; abort only skips the rest
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else if (r_addr == ADDR_LAST) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_READ;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, address, latency timer, counters and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_addr     <= {ADDR_WIDTH{1'b0}};
         r_wait     <= {WAIT_W{1'b0}};
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mem_en   <= 1'b0;
         r_corr     <= {(ADDR_WIDTH+1){1'b0}};
         r_uncorr   <= {(ADDR_WIDTH+1){1'b0}};
         r_last_err <= {ADDR_WIDTH{1'b0}};
      end else begin
         r_state  <= w_state_nxt;
         // outputs follow the state being entered so they line up with it
         r_busy   <= (w_state_nxt != S_IDLE);
         r_done   <= (w_state_nxt == S_DONE);
         r_mem_en <= (w_state_nxt == S_READ) || (w_state_nxt == S_WRITE);

         if (r_state == S_WAIT) begin
            r_wait <= r_wait + {{(WAIT_W-1){1'b0}}, 1'b1};
         end else begin
            r_wait <= {WAIT_W{1'b0}};
         end

         if ((r_state == S_IDLE) && (w_state_nxt == S_READ)) begin
            r_addr   <= {ADDR_WIDTH{1'b0}};
            r_corr   <= {(ADDR_WIDTH+1){1'b0}};
            r_uncorr <= {(ADDR_WIDTH+1){1'b0}};
         end else if ((r_state == S_NEXT) && (w_state_nxt == S_READ)) begin
            r_addr <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         end else if ((r_state == S_CHECK) && !i_abort) begin
            case (w_status)
               ECC_CORR: begin
                  if (r_corr != CNT_MAX) begin
                     r_corr <= r_corr + {{ADDR_WIDTH{1'b0}}, 1'b1};
                  end
                  r_last_err <= r_addr;
               end
               ECC_UNCORR: begin
                  if (r_uncorr != CNT_MAX) begin
                     r_uncorr <= r_uncorr + {{ADDR_WIDTH{1'b0}}, 1'b1};
                  end
                  r_last_err <= r_addr;
               end
               default: begin
               end
            endcase
         end
      end
   end

`ifdef SCRUB_WRITEBACK_EN
   logic                  r_mem_we;
   logic [CODE_WIDTH-1:0] r_mem_din;

   // Write-back strobe and data, captured from the decoder in CHECK
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mem_we  <= 1'b0;
         r_mem_din <= {CODE_WIDTH{1'b0}};
      end else begin
         r_mem_we <= (w_state_nxt == S_WRITE);
         if ((r_state == S_CHECK) && (w_state_nxt == S_WRITE)) begin
            r_mem_din <= w_corrected;
         end else if (w_state_nxt != S_WRITE) begin
            r_mem_din <= {CODE_WIDTH{1'b0}};
         end
      end
   end

   assign o_mem_we    = r_mem_we;
   assign o_mem_din   = r_mem_din;
   assign w_unused_ok = ^{w_syndrome, w_data};
`else
   assign o_mem_we    = 1'b0;
   assign o_mem_din   = {CODE_WIDTH{1'b0}};
   assign w_unused_ok = ^{w_syndrome, w_data, w_corrected};
`endif

   assign o_mem_en        = r_mem_en;
   assign o_mem_addr      = r_addr;
   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_corr_count    = r_corr;
   assign o_uncorr_count  = r_uncorr;
   assign o_last_err_addr = r_last_err;

endmodule

// File: tb/tb_ecc_memory_scrubber.sv
// ---------------------------------------------------------------------------
// tb_ecc_memory_scrubber
// Scoreboard bench: stimulus pushes expected write-backs and end-of-pass
// results into a queue; a monitor pops and compares whenever the scrubber
// writes memory or pulses o_done. A behavioural memory with 5-clock read
// latency backs the DUT. Adapts to the SCRUB_WRITEBACK_EN build option.
// ---------------------------------------------------------------------------
module tb_ecc_memory_scrubber;

   logic        clk = 1'b0;
   logic        i_rst, i_start, i_abort;
   logic        o_mem_en, o_mem_we, o_busy, o_done;
   logic [4:0]  o_mem_addr, o_last_err_addr;
   logic [11:0] o_mem_din, i_mem_dout;
   logic [5:0]  o_corr_count, o_uncorr_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_done;
      logic [4:0]  addr;
      logic [11:0] data;
      int          lat;
      logic [5:0]  corr;
      logic [5:0]  uncorr;
      logic [4:0]  last;
      int          reads;
   } ev_t;
   ev_t exp_q[$];

   always #5 clk = ~clk;

   ecc_memory_scrubber #(
      .WIDTH(8), .CODE_WIDTH(12), .ADDR_WIDTH(5), .READ_LATENCY(5), .DEPTH(32)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_din(o_mem_din), .i_mem_dout(i_mem_dout), .o_busy(o_busy),
      .o_done(o_done), .o_corr_count(o_corr_count),
      .o_uncorr_count(o_uncorr_count), .o_last_err_addr(o_last_err_addr)
   );

   // Behavioural memory: 5-clock read latency, data held until next read
   logic [11:0] mem [32];
   logic        poke_en = 1'b0;
   logic [4:0]  poke_addr = 5'd0;
   logic [11:0] poke_data = 12'h000;
   logic [4:0]  pend_addr = 5'd0;
   logic [2:0]  rd_cnt = 3'd0;
   logic [11:0] dout_r = 12'h000;
   assign i_mem_dout = dout_r;

   always @(posedge clk) begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (o_mem_en && o_mem_we) mem[o_mem_addr] <= o_mem_din;
      if (o_mem_en && !o_mem_we) begin
         pend_addr <= o_mem_addr;
         rd_cnt    <= 3'd5;
      end else if (rd_cnt != 3'd0) begin
         rd_cnt <= rd_cnt - 3'd1;
         if (rd_cnt == 3'd1) dout_r <= mem[pend_addr];
      end
   end

   // Reference Hamming encoder built from the position rules
   function automatic logic [11:0] enc(input logic [7:0] d);
      logic [11:0] c;
      int j;
      c = 12'h000;
      j = 0;
      for (int p = 1; p <= 12; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p-1] = d[j];
            j++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         logic par;
         par = 1'b0;
         for (int p = 1; p <= 12; p++) if (p[k]) par ^= c[p-1];
         c[(1 << k) - 1] = par;
      end
      return c;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [4:0] a, input logic [11:0] d);
      poke_addr = a;
      poke_data = d;
      poke_en   = 1'b1;
      tick();
      poke_en   = 1'b0;
   endtask

   task automatic load_clean();
      for (int i = 0; i < 32; i++) poke(5'(i), enc(8'(i)));
   endtask

   task automatic push_write(input logic [4:0] a, input logic [11:0] d);
      ev_t e;
      e = '{is_done: 1'b0, addr: a, data: d, lat: 0, corr: 6'd0, uncorr: 6'd0, last: 5'd0, reads: 0};
      exp_q.push_back(e);
   endtask

   task automatic push_done(input int lat, input logic [5:0] c, input logic [5:0] u, input logic [4:0] l);
      ev_t e;
      e = '{is_done: 1'b1, addr: 5'd0, data: 12'h000, lat: lat, corr: c, uncorr: u, last: l, reads: 32};
      exp_q.push_back(e);
   endtask

   task automatic start_pulse();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         if (o_done) seen = 1'b1;
         else tick();
      end
      chk({name, "_done_seen"}, int'(seen), 1);
      tick();
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_en"}, int'(o_mem_en), 0);
      chk({name, "_we"}, int'(o_mem_we), 0);
      chk({name, "_addr"}, int'(o_mem_addr), 0);
      chk({name, "_din"}, int'(o_mem_din), 0);
      chk({name, "_busy"}, int'(o_busy), 0);
      chk({name, "_done"}, int'(o_done), 0);
      chk({name, "_corr"}, int'(o_corr_count), 0);
      chk({name, "_uncorr"}, int'(o_uncorr_count), 0);
      chk({name, "_last"}, int'(o_last_err_addr), 0);
   endtask

   // Monitor: pops the scoreboard on every memory write and o_done pulse
   initial begin
      int  cyc, start_cyc, reads;
      bit  prev_busy;
      ev_t e;
      cyc = 0; start_cyc = 0; reads = 0; prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (o_busy && !prev_busy) begin
            start_cyc = cyc;
            reads     = 0;
         end
         if (o_mem_en && !o_mem_we) reads++;
         if (o_mem_en && o_mem_we) begin
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0d data 0x%03h, expected no write", o_mem_addr, o_mem_din);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", int'(o_mem_addr), int'(e.addr));
               chk("write_data", int'(o_mem_din), int'(e.data));
            end
         end
         if (o_done) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got o_done=1 at cycle %0d, expected no done", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("done_latency", cyc - start_cyc, e.lat);
               chk("done_reads", reads, e.reads);
               chk("done_corr", int'(o_corr_count), int'(e.corr));
               chk("done_uncorr", int'(o_uncorr_count), int'(e.uncorr));
               chk("done_last_err", int'(o_last_err_addr), int'(e.last));
            end
         end
         prev_busy = o_busy;
      end
   end

   // Watchdog so the run always terminates
   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      bit found;
      i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
      repeat (3) tick();
      i_rst = 1'b0;
      chk_all_zero("reset");
      load_clean();

      // Clean pass
      push_done(256, 6'd0, 6'd0, 5'd0);
      start_pulse();
      wait_done("clean");

      // Single error: 0xA5 codeword 0xA27 with position 6 flipped
      poke(5'd3, 12'hA07);
`ifdef SCRUB_WRITEBACK_EN
      push_write(5'd3, 12'hA27);
      push_done(257, 6'd1, 6'd0, 5'd3);
`else
      push_done(256, 6'd1, 6'd0, 5'd3);
`endif
      start_pulse();
      wait_done("single");
      poke(5'd3, enc(8'd3));

      // Uncorrectable: positions 5 and 8 flipped at addr 7
      poke(5'd7, enc(8'd7) ^ 12'h090);
      push_done(256, 6'd0, 6'd1, 5'd7);
      start_pulse();
      wait_done("uncorr");
      poke(5'd7, enc(8'd7));

      // Abort during WAIT of addr 10, after a correctable error at addr 2
      poke(5'd2, enc(8'd2) ^ 12'h001);
`ifdef SCRUB_WRITEBACK_EN
      push_write(5'd2, enc(8'd2));
`endif
      start_pulse();
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         if (o_mem_en && !o_mem_we && o_mem_addr == 5'd10) found = 1'b1;
         else tick();
      end
      chk("abort_reach_addr10", int'(found), 1);
      tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_done", int'(o_done), 0);
      chk("abort_en", int'(o_mem_en), 0);
      chk("abort_corr_held", int'(o_corr_count), 1);
      chk("abort_last_held", int'(o_last_err_addr), 2);
      repeat (5) tick();
      chk("abort_still_idle", int'(o_busy), 0);
      poke(5'd2, enc(8'd2));
      push_done(256, 6'd0, 6'd0, 5'd2);
      start_pulse();
      chk("restart_first_en", int'(o_mem_en), 1);
      chk("restart_first_addr", int'(o_mem_addr), 0);
      chk("restart_corr_cleared", int'(o_corr_count), 0);
      wait_done("restart");

      // Reset in the middle of the write of addr 3
      poke(5'd3, 12'hA07);
`ifdef SCRUB_WRITEBACK_EN
      push_write(5'd3, 12'hA27);
`endif
      start_pulse();
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
`ifdef SCRUB_WRITEBACK_EN
         if (o_mem_en && o_mem_we) found = 1'b1;
`else
         if (o_mem_en && o_mem_addr == 5'd3) found = 1'b1;
`endif
         else tick();
      end
      chk("rst_reach_addr3", int'(found), 1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk_all_zero("midpass_reset");
      poke(5'd3, enc(8'd3));

      // Start while busy is ignored
      push_done(256, 6'd0, 6'd0, 5'd0);
      start_pulse();
      repeat (20) tick();
      start_pulse();
      wait_done("busy_start");

      // Start and abort together in IDLE
      i_start = 1'b1;
      i_abort = 1'b1;
      tick();
      i_start = 1'b0;
      i_abort = 1'b0;
      chk("start_abort_busy", int'(o_busy), 0);
      chk("start_abort_en", int'(o_mem_en), 0);
      repeat (3) tick();
      chk("start_abort_idle", int'(o_busy), 0);

      repeat (3) tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
